// File: rtl/dm_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package dm_arb_pkg;

    localparam int unsigned DATA_W_DEF   = 32;
    localparam int unsigned DM_DEPTH_DEF = 256;
    localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } state_t;

    typedef enum logic {
        TAG_A = 1'b0,
        TAG_B = 1'b1
    } tag_t;

endpackage

// File: rtl/dm_arb_resp_pipe.sv
// Read response pipeline: remembers who issued a read, captures DM read data a cycle later
// and presents it as a registered rvalid/rdata pulse to the owning requester.
module dm_arb_resp_pipe
    import dm_arb_pkg::*;
#(
    parameter int unsigned       DATA_W   = DATA_W_DEF,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  tag_t              issue_tag,
    input  logic              issue_err,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              err
);

    logic s1_valid;
    tag_t s1_tag;
    logic s1_err;
    logic [DATA_W-1:0] cap_data;

    // A rejected read never reached DM, so substitute the error word
    assign cap_data = s1_err ? ERR_DATA : dm_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_tag   <= TAG_A;
            s1_err   <= 1'b0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
            err      <= 1'b0;
        end else begin
            s1_valid <= issue_valid;
            s1_tag   <= issue_tag;
            s1_err   <= issue_valid & issue_err;
            a_rvalid <= s1_valid && (s1_tag == TAG_A);
            b_rvalid <= s1_valid && (s1_tag == TAG_B);
            err      <= s1_valid & s1_err;
            if (s1_valid && (s1_tag == TAG_A)) a_rdata <= cap_data;
            if (s1_valid && (s1_tag == TAG_B)) b_rdata <= cap_data;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between CPU (A) and debug/DMA (B),
// with locked sequences. Optional address range check: DM_ARB_RANGE_CHK_EN.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int unsigned       DATA_W   = DATA_W_DEF,
    parameter int unsigned       DM_DEPTH = DM_DEPTH_DEF,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic              a_lock,
    input  logic [31:0]       a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic              b_lock,
    input  logic [31:0]       b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              dm_mem_read,
    output logic              dm_mem_write,
    output logic [31:0]       dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic              err
);

`ifdef DM_ARB_RANGE_CHK_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif
    localparam logic [31:0] ADDR_LIMIT = 32'(DM_DEPTH * 4);

    state_t state;
    logic   prefer_a;
    logic   sel_a, sel_b, any_sel;
    logic   sel_we;
    logic [31:0]       sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic   rej, issue, pipe_err;

    // Grant selection; nothing is granted while reset is held
    always_comb begin
        sel_a = 1'b0;
        sel_b = 1'b0;
        if (!rst) begin
            case (state)
                ARB: begin
                    if (a_req && (!b_req || prefer_a)) sel_a = 1'b1;
                    else if (b_req)                    sel_b = 1'b1;
                end
                LOCK_A:  sel_a = a_req;
                LOCK_B:  sel_b = b_req;
                default: ;
            endcase
        end
    end

    assign any_sel   = sel_a | sel_b;
    assign sel_we    = sel_a ? a_we    : b_we;
    assign sel_addr  = sel_a ? a_addr  : b_addr;
    assign sel_wdata = sel_a ? a_wdata : b_wdata;

    assign rej   = RANGE_CHK && any_sel && (sel_addr >= ADDR_LIMIT);
    assign issue = any_sel & ~rej;

    assign a_gnt        = sel_a;
    assign b_gnt        = sel_b;
    assign dm_mem_read  = issue & ~sel_we;
    assign dm_mem_write = issue & sel_we;
    assign dm_addr      = issue ? sel_addr  : 32'd0;
    assign dm_wdata     = issue ? sel_wdata : '0;

    // Rejected writes flag err at grant; rejected reads flag it with their response
    assign err = (rej & sel_we) | pipe_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB;
            prefer_a <= 1'b1;
        end else if (sel_a) begin
            prefer_a <= 1'b0;
            state    <= a_lock ? LOCK_A : ARB;
        end else if (sel_b) begin
            prefer_a <= 1'b1;
            state    <= b_lock ? LOCK_B : ARB;
        end
    end

    dm_arb_resp_pipe #(
        .DATA_W   (DATA_W),
        .ERR_DATA (ERR_DATA)
    ) u_resp_pipe (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (any_sel & ~sel_we),
        .issue_tag   (sel_b ? TAG_B : TAG_A),
        .issue_err   (rej),
        .dm_rdata    (dm_rdata),
        .a_rvalid    (a_rvalid),
        .a_rdata     (a_rdata),
        .b_rvalid    (b_rvalid),
        .b_rdata     (b_rdata),
        .err         (pipe_err)
    );

endmodule
